// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access -- memory-access pipeline stage
//
// Holds one instruction from the execute stage in a stage register. Non-memory
// results pass straight through to write-back. Loads and stores run a
// request/response handshake on the data bus through a small FSM:
//   IDLE -> REQ (data_req high until data_addr_ok) -> WAIT (until data_data_ok)
//   -> DONE (one cycle; load result presented to write-back).
// A response may arrive in the same cycle as the address acceptance, in which
// case REQ goes straight to DONE. Misaligned half/word accesses never reach
// the bus; they raise ale_o/badv_o while the entry is held.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   stall_i, flush_i    pipeline hold / discard of the captured instruction
//   we_i, waddr_i,      register write request and Ex result
//   wdata_i
//   aluop_i             operation code (load/store codes below)
//   mem_addr_i, reg1_i  effective address and store data
//   we_o, waddr_o,      result to write-back
//   wdata_o
//   stallreq_o          freeze upstream while a bus transaction is open
//   ale_o, badv_o       misaligned-address flag and faulting address
//   data_*              data bus master (req/wr/size/wstrb/addr/wdata out,
//                       addr_ok/data_ok/rdata in)
//
// Byte-lane logic assumes a 32-bit data bus (four lanes).
// ---------------------------------------------------------------------------
module mem_access #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_i,
    input  logic          flush_i,
    input  logic          we_i,
    input  logic [4:0]    waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [7:0]    aluop_i,
    input  logic [AW-1:0] mem_addr_i,
    input  logic [DW-1:0] reg1_i,
    output logic          we_o,
    output logic [4:0]    waddr_o,
    output logic [DW-1:0] wdata_o,
    output logic          stallreq_o,
    output logic          ale_o,
    output logic [AW-1:0] badv_o,
    output logic          data_req,
    output logic          data_wr,
    output logic [1:0]    data_size,
    output logic [3:0]    data_wstrb,
    output logic [AW-1:0] data_addr,
    output logic [DW-1:0] data_wdata,
    input  logic          data_addr_ok,
    input  logic          data_data_ok,
    input  logic [DW-1:0] data_rdata
);

    // -----------------------------------------------------------------------
    // Operation codes for memory instructions
    // -----------------------------------------------------------------------
    localparam logic [7:0] EXE_OP_LD_B  = 8'h20;
    localparam logic [7:0] EXE_OP_LD_H  = 8'h21;
    localparam logic [7:0] EXE_OP_LD_W  = 8'h22;
    localparam logic [7:0] EXE_OP_LD_BU = 8'h23;
    localparam logic [7:0] EXE_OP_LD_HU = 8'h24;
    localparam logic [7:0] EXE_OP_ST_B  = 8'h28;
    localparam logic [7:0] EXE_OP_ST_H  = 8'h29;
    localparam logic [7:0] EXE_OP_ST_W  = 8'h2A;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // -----------------------------------------------------------------------
    // Opcode decode helpers
    // -----------------------------------------------------------------------
    function automatic logic is_load(input logic [7:0] op);
        return (op == EXE_OP_LD_B)  || (op == EXE_OP_LD_H) ||
               (op == EXE_OP_LD_W)  || (op == EXE_OP_LD_BU) ||
               (op == EXE_OP_LD_HU);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == EXE_OP_ST_B) || (op == EXE_OP_ST_H) ||
               (op == EXE_OP_ST_W);
    endfunction

    function automatic logic [1:0] op_size(input logic [7:0] op);
        logic [1:0] sz;
        case (op)
            EXE_OP_LD_B, EXE_OP_LD_BU, EXE_OP_ST_B: sz = SIZE_BYTE;
            EXE_OP_LD_H, EXE_OP_LD_HU, EXE_OP_ST_H: sz = SIZE_HALF;
            default:                                sz = SIZE_WORD;
        endcase
        return sz;
    endfunction

    // Only meaningful for memory ops; the caller qualifies with is_load/is_store.
    function automatic logic op_aligned(input logic [7:0] op, input logic [1:0] lane);
        logic ok;
        case (op_size(op))
            SIZE_HALF: ok = ~lane[0];
            SIZE_WORD: ok = (lane == 2'b00);
            default:   ok = 1'b1;
        endcase
        return ok;
    endfunction

    // -----------------------------------------------------------------------
    // State and stage register
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          valid_q, valid_d;
    logic          we_q,    we_d;
    logic [4:0]    waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [7:0]    aluop_q, aluop_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [DW-1:0] sdata_q, sdata_d;
    logic [DW-1:0] ldata_q, ldata_d;   // extended load result, latched on data_ok

    // Decode of the held instruction
    logic       ld_q;
    logic       st_q;
    logic       mem_q;
    logic [1:0] size_q;
    logic [1:0] lane_q;
    logic       misaligned_q;

    assign ld_q         = is_load(aluop_q);
    assign st_q         = is_store(aluop_q);
    assign mem_q        = ld_q | st_q;
    assign size_q       = op_size(aluop_q);
    assign lane_q       = addr_q[1:0];
    assign misaligned_q = valid_q & mem_q & ~op_aligned(aluop_q, lane_q);

    // Decode of the incoming instruction (decides REQ vs IDLE on capture)
    logic in_mem;
    logic in_aligned;

    assign in_mem     = is_load(aluop_i) | is_store(aluop_i);
    assign in_aligned = op_aligned(aluop_i, mem_addr_i[1:0]);

    // The stage register is open only when no bus transaction is in flight.
    logic capture;
    assign capture = ~stall_i & ((state_q == S_IDLE) | (state_q == S_DONE));

    // -----------------------------------------------------------------------
    // Byte/half lane views of read data and replicated store data
    // -----------------------------------------------------------------------
    logic [7:0]    rd_byte [4];
    logic [15:0]   rd_half [2];
    logic [DW-1:0] st_byte_rep;
    logic [DW-1:0] st_half_rep;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign rd_byte[gi]           = data_rdata[8*gi +: 8];
            assign st_byte_rep[8*gi +: 8] = sdata_q[7:0];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half_lane
            assign rd_half[gi]             = data_rdata[16*gi +: 16];
            assign st_half_rep[16*gi +: 16] = sdata_q[15:0];
        end
    endgenerate

    // Load extension from the lane selected by the held address
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic [DW-1:0] load_ext;

    always_comb begin
        sel_byte = rd_byte[lane_q];
        sel_half = rd_half[lane_q[1]];
        case (aluop_q)
            EXE_OP_LD_B:  load_ext = {{(DW-8){sel_byte[7]}}, sel_byte};
            EXE_OP_LD_BU: load_ext = {{(DW-8){1'b0}}, sel_byte};
            EXE_OP_LD_H:  load_ext = {{(DW-16){sel_half[15]}}, sel_half};
            EXE_OP_LD_HU: load_ext = {{(DW-16){1'b0}}, sel_half};
            default:      load_ext = data_rdata;
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        aluop_d = aluop_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        ldata_d = ldata_q;

        if (capture) begin
            valid_d = ~flush_i;
            we_d    = we_i;
            waddr_d = waddr_i;
            wdata_d = wdata_i;
            aluop_d = aluop_i;
            addr_d  = mem_addr_i;
            sdata_d = reg1_i;
            // Misaligned or flushed memory ops stay in IDLE and never touch the bus.
            if (~flush_i & in_mem & in_aligned) begin
                state_d = S_REQ;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (data_addr_ok) begin
                        if (data_data_ok) begin
                            state_d = S_DONE;
                            ldata_d = load_ext;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (data_data_ok) begin
                        state_d = S_DONE;
                        ldata_d = load_ext;
                    end
                end
                // IDLE/DONE without capture means stall_i is high: hold.
                default: state_d = state_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            aluop_q <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            ldata_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            aluop_q <= aluop_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            ldata_q <= ldata_d;
        end
    end

    // -----------------------------------------------------------------------
    // Write-back and control outputs (decoded from registered state only)
    // -----------------------------------------------------------------------
    logic bus_busy;
    assign bus_busy = (state_q == S_REQ) | (state_q == S_WAIT);

    always_comb begin
        we_o    = 1'b0;
        waddr_o = '0;
        wdata_o = '0;
        if (valid_q) begin
            waddr_o = waddr_q;
            wdata_o = wdata_q;
            case (state_q)
                S_IDLE:  we_o = we_q & ~mem_q;   // memory ops here are misaligned
                S_DONE: begin
                    we_o = ld_q;
                    if (ld_q) begin
                        wdata_o = ldata_q;
                    end
                end
                default: we_o = 1'b0;
            endcase
        end
    end

    assign stallreq_o = bus_busy;
    assign ale_o      = misaligned_q;
    assign badv_o     = misaligned_q ? addr_q : '0;

    // -----------------------------------------------------------------------
    // Data bus outputs: all attributes come straight from the stage register,
    // which cannot change while the FSM is in REQ/WAIT, so they stay stable
    // until the address is accepted.
    // -----------------------------------------------------------------------
    always_comb begin
        data_req   = (state_q == S_REQ);
        data_wr    = 1'b0;
        data_size  = 2'd0;
        data_wstrb = 4'b0000;
        data_addr  = '0;
        data_wdata = '0;
        if (bus_busy) begin
            data_wr   = st_q;
            data_size = size_q;
            data_addr = (size_q == SIZE_WORD) ? {addr_q[AW-1:2], 2'b00} : addr_q;
            case (aluop_q)
                EXE_OP_ST_B: begin
                    data_wstrb = 4'b0001 << lane_q;
                    data_wdata = st_byte_rep;
                end
                EXE_OP_ST_H: begin
                    data_wstrb = 4'b0011 << lane_q;
                    data_wdata = st_half_rep;
                end
                EXE_OP_ST_W: begin
                    data_wstrb = 4'b1111;
                    data_wdata = sdata_q;
                end
                default: begin
                    data_wstrb = 4'b0000;
                    data_wdata = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access -- directed self-checking bench for mem_access.
// Expected write-back results are queued when an instruction is issued and
// popped by a monitor whenever the DUT asserts we_o.
// ---------------------------------------------------------------------------
module tb_mem_access;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_ADD   = 8'h01;
    localparam logic [7:0] OP_LD_B  = 8'h20;
    localparam logic [7:0] OP_LD_H  = 8'h21;
    localparam logic [7:0] OP_LD_W  = 8'h22;
    localparam logic [7:0] OP_LD_BU = 8'h23;
    localparam logic [7:0] OP_LD_HU = 8'h24;
    localparam logic [7:0] OP_ST_B  = 8'h28;
    localparam logic [7:0] OP_ST_H  = 8'h29;
    localparam logic [7:0] OP_ST_W  = 8'h2A;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] reg1_i;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;
    logic        ale_o;
    logic [31:0] badv_o;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    mem_access #(.AW(32), .DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .we_i         (we_i),
        .waddr_i      (waddr_i),
        .wdata_i      (wdata_i),
        .aluop_i      (aluop_i),
        .mem_addr_i   (mem_addr_i),
        .reg1_i       (reg1_i),
        .we_o         (we_o),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o),
        .stallreq_o   (stallreq_o),
        .ale_o        (ale_o),
        .badv_o       (badv_o),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } wb_t;

    wb_t exp_q[$];
    int  checks    = 0;
    int  fails     = 0;
    int  stall_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},     {31'b0, we_o},       32'h0);
        chk({tag, "_waddr"},  {27'b0, waddr_o},    32'h0);
        chk({tag, "_wdata"},  wdata_o,             32'h0);
        chk({tag, "_stall"},  {31'b0, stallreq_o}, 32'h0);
        chk({tag, "_ale"},    {31'b0, ale_o},      32'h0);
        chk({tag, "_badv"},   badv_o,              32'h0);
        chk({tag, "_req"},    {31'b0, data_req},   32'h0);
        chk({tag, "_wr"},     {31'b0, data_wr},    32'h0);
        chk({tag, "_size"},   {30'b0, data_size},  32'h0);
        chk({tag, "_wstrb"},  {28'b0, data_wstrb}, 32'h0);
        chk({tag, "_addr"},   data_addr,           32'h0);
        chk({tag, "_bwdata"}, data_wdata,          32'h0);
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (stallreq_o) stall_cnt++;
    endtask

    task automatic bubble();
        stall_i    = 1'b0;
        flush_i    = 1'b0;
        we_i       = 1'b0;
        waddr_i    = 5'd0;
        wdata_i    = 32'h0;
        aluop_i    = OP_NOP;
        mem_addr_i = 32'h0;
        reg1_i     = 32'h0;
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        aluop_i    = op;
        mem_addr_i = addr;
        reg1_i     = sdata;
        we_i       = we;
        waddr_i    = wa;
        wdata_i    = wd;
    endtask

    // Aligned load acknowledged with addr_ok and data_ok in the same cycle.
    task automatic fast_load(input string tag, input logic [7:0] op, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [4:0] wa, input logic [31:0] exp);
        wb_t e;
        issue(op, addr, 32'h0, 1'b1, wa, 32'hDEAD_0000);
        e.waddr = wa;
        e.wdata = exp;
        exp_q.push_back(e);
        tick();
        bubble();
        chk({tag, "_req"}, {31'b0, data_req}, 32'h1);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = rdata;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        chk({tag, "_we"},    {31'b0, we_o}, 32'h1);
        chk({tag, "_wdata"}, wdata_o,       exp);
        tick();
    endtask

    // Write-back monitor: every we_o pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (!rst && we_o) begin
            $display("wb waddr=%0d wdata=%h", waddr_o, wdata_o);
            checks++;
            assert (exp_q.size() > 0) else begin
                fails++;
                $error("FAIL wb_unexpected: observed waddr=%0d wdata=%h expected none", waddr_o, wdata_o);
            end
            if (exp_q.size() > 0) begin
                wb_t e;
                e = exp_q.pop_front();
                checks++;
                assert ({waddr_o, wdata_o} === {e.waddr, e.wdata}) else begin
                    fails++;
                    $error("FAIL wb_data: observed %0d/%h expected %0d/%h", waddr_o, wdata_o, e.waddr, e.wdata);
                end
            end
        end
    end

    initial begin
        wb_t e;
        rst          = 1'b1;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        bubble();
        #2;
        chk_all_zero("reset");
        #10;
        rst = 1'b0;
        tick();

        // ADD pass-through, zero extra latency
        issue(OP_ADD, 32'h0, 32'h0, 1'b1, 5'd5, 32'h0000_1234);
        e.waddr = 5'd5; e.wdata = 32'h0000_1234; exp_q.push_back(e);
        tick();
        bubble();
        chk("add_we",    {31'b0, we_o},       32'h1);
        chk("add_waddr", {27'b0, waddr_o},    32'h5);
        chk("add_wdata", wdata_o,             32'h0000_1234);
        chk("add_stall", {31'b0, stallreq_o}, 32'h0);
        chk("add_req",   {31'b0, data_req},   32'h0);
        tick();
        chk("add_after_we", {31'b0, we_o}, 32'h0);

        // stall_i blocks capture
        stall_i = 1'b1;
        issue(OP_ADD, 32'h0, 32'h0, 1'b1, 5'd2, 32'h0000_0055);
        tick();
        chk("stall_hold_we", {31'b0, we_o}, 32'h0);
        stall_i = 1'b0;
        e.waddr = 5'd2; e.wdata = 32'h0000_0055; exp_q.push_back(e);
        tick();
        bubble();
        chk("stall_rel_we", {31'b0, we_o}, 32'h1);
        tick();

        // LD.B 0x1003: addr_ok after 2 cycles, data_ok 3 cycles later
        issue(OP_LD_B, 32'h0000_1003, 32'h0, 1'b1, 5'd7, 32'h0);
        e.waddr = 5'd7; e.wdata = 32'hFFFF_FF80; exp_q.push_back(e);
        stall_cnt = 0;
        tick();
        bubble();
        chk("ldb_stall",  {31'b0, stallreq_o}, 32'h1);
        chk("ldb_req",    {31'b0, data_req},   32'h1);
        chk("ldb_addr",   data_addr,           32'h0000_1003);
        chk("ldb_size",   {30'b0, data_size},  32'h0);
        chk("ldb_wr",     {31'b0, data_wr},    32'h0);
        chk("ldb_wstrb",  {28'b0, data_wstrb}, 32'h0);
        chk("ldb_we_req", {31'b0, we_o},       32'h0);
        tick();
        chk("ldb_addr_stable", data_addr, 32'h0000_1003);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        chk("ldb_wait_req",   {31'b0, data_req},   32'h0);
        chk("ldb_wait_stall", {31'b0, stallreq_o}, 32'h1);
        tick();
        tick();
        data_data_ok = 1'b1;
        data_rdata   = 32'h80FF_FFFF;
        tick();
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        chk("ldb_stall_cycles", stall_cnt,          32'd5);
        chk("ldb_done_stall",   {31'b0, stallreq_o}, 32'h0);
        chk("ldb_done_we",      {31'b0, we_o},       32'h1);
        chk("ldb_done_wdata",   wdata_o,             32'hFFFF_FF80);
        tick();
        chk("ldb_idle_we", {31'b0, we_o}, 32'h0);

        // ST.H 0x2002 with same-cycle acknowledge; store forces we_o low
        issue(OP_ST_H, 32'h0000_2002, 32'hABCD_1234, 1'b1, 5'd9, 32'h0);
        tick();
        bubble();
        chk("sth_wstrb", {28'b0, data_wstrb}, 32'hC);
        chk("sth_wdata", data_wdata,          32'h1234_1234);
        chk("sth_size",  {30'b0, data_size},  32'h1);
        chk("sth_wr",    {31'b0, data_wr},    32'h1);
        chk("sth_addr",  data_addr,           32'h0000_2002);
        chk("sth_we",    {31'b0, we_o},       32'h0);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        chk("sth_done_stall", {31'b0, stallreq_o}, 32'h0);
        chk("sth_done_we",    {31'b0, we_o},       32'h0);
        tick();

        // ST.B and ST.W formatting
        issue(OP_ST_B, 32'h0000_5001, 32'h1122_3377, 1'b0, 5'd0, 32'h0);
        tick();
        bubble();
        chk("stb_wstrb", {28'b0, data_wstrb}, 32'h2);
        chk("stb_wdata", data_wdata,          32'h7777_7777);
        chk("stb_addr",  data_addr,           32'h0000_5001);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        tick();
        issue(OP_ST_W, 32'h0000_5004, 32'hCAFE_F00D, 1'b0, 5'd0, 32'h0);
        tick();
        bubble();
        chk("stw_wstrb", {28'b0, data_wstrb}, 32'hF);
        chk("stw_wdata", data_wdata,          32'hCAFE_F00D);
        chk("stw_size",  {30'b0, data_size},  32'h2);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        tick();

        // Misaligned accesses
        issue(OP_LD_W, 32'h0000_3001, 32'h0, 1'b1, 5'd8, 32'h0);
        tick();
        bubble();
        chk("ldw_mis_ale",   {31'b0, ale_o},      32'h1);
        chk("ldw_mis_badv",  badv_o,              32'h0000_3001);
        chk("ldw_mis_req",   {31'b0, data_req},   32'h0);
        chk("ldw_mis_we",    {31'b0, we_o},       32'h0);
        chk("ldw_mis_stall", {31'b0, stallreq_o}, 32'h0);
        tick();
        chk("ldw_mis_clear", {31'b0, ale_o}, 32'h0);
        issue(OP_LD_H, 32'h0000_3003, 32'h0, 1'b1, 5'd8, 32'h0);
        tick();
        bubble();
        chk("ldh_mis_ale",  {31'b0, ale_o}, 32'h1);
        chk("ldh_mis_badv", badv_o,         32'h0000_3003);
        tick();

        // Load extension variants
        fast_load("ldh",  OP_LD_H,  32'h0000_7000, 32'h1234_F00D, 5'd10, 32'hFFFF_F00D);
        fast_load("ldbu", OP_LD_BU, 32'h0000_7001, 32'h0000_9A00, 5'd11, 32'h0000_009A);
        fast_load("ldw",  OP_LD_W,  32'h0000_7004, 32'h8765_4321, 5'd12, 32'h8765_4321);

        // Reset pulse during WAIT abandons the load
        issue(OP_LD_W, 32'h0000_6000, 32'h0, 1'b1, 5'd3, 32'h0);
        tick();
        bubble();
        chk("rstw_size", {30'b0, data_size}, 32'h2);
        chk("rstw_addr", data_addr,          32'h0000_6000);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        chk("rstw_wait", {31'b0, stallreq_o}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_async");
        #3;
        rst = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'h5555_AAAA;
        tick();
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        chk_all_zero("rst_after");
        tick();

        // Flush during WAIT of LD.HU is ignored; flush on the next capture kills it
        issue(OP_LD_HU, 32'h0000_4002, 32'h0, 1'b1, 5'd4, 32'h0);
        e.waddr = 5'd4; e.wdata = 32'h0000_8001; exp_q.push_back(e);
        tick();
        bubble();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        flush_i = 1'b1;
        tick();
        chk("flush_wait_stall", {31'b0, stallreq_o}, 32'h1);
        data_data_ok = 1'b1;
        data_rdata   = 32'h8001_0000;
        tick();
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        chk("flush_done_we",    {31'b0, we_o},    32'h1);
        chk("flush_done_wdata", wdata_o,          32'h0000_8001);
        chk("flush_done_waddr", {27'b0, waddr_o}, 32'h4);
        issue(OP_ADD, 32'h0, 32'h0, 1'b1, 5'd6, 32'h0000_0066);
        flush_i = 1'b1;
        tick();
        bubble();
        chk("flush_cap_we", {31'b0, we_o}, 32'h0);
        tick();

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
